// File: rtl/pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg
//
// Inter-stage pipeline register with a 2-entry skid buffer. The payload plus
// the destination-register fields (rd, regwrite) move under a valid/ready
// handshake. in_ready comes straight from a flop, so downstream back-pressure
// never forms a combinational path back into the upstream stage.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 (in_fire = in_valid & in_ready, out_fire = out_valid & out_ready).
// in_valid is ignored while in_ready is 0. While out_valid=1 and
// out_ready=0, every out_* signal is held stable. Ordering is strictly FIFO.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high (overrides flush/transfers)
//   flush        synchronous squash of held and incoming entries
//   in_valid     upstream entry valid
//   in_ready     space available (registered, equals !skid_valid)
//   in_data      upstream payload
//   in_rd        upstream destination register
//   in_regwrite  upstream register-write enable
//   out_valid    main entry valid
//   out_ready    downstream accepts
//   out_data     main entry payload
//   out_rd       main entry rd
//   out_regwrite main regwrite qualified by main valid
//   haz_rd_main  rd of main entry
//   haz_we_main  main entry will write a nonzero register
//   haz_rd_skid  rd of skid entry
//   haz_we_skid  skid entry will write a nonzero register
//   occupancy    number of held entries, 0..2
//
// The internal `state` signal ({main_valid, skid_valid}) is the FSM state and
// can be probed hierarchically.
// ---------------------------------------------------------------------------
module pipe_stage_skid_reg #(
    parameter int DATA_W     = 32,
    parameter int RD_W       = 5,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_regwrite,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_regwrite,
    output logic [RD_W-1:0]   haz_rd_main,
    output logic              haz_we_main,
    output logic [RD_W-1:0]   haz_rd_skid,
    output logic              haz_we_skid,
    output logic [1:0]        occupancy
);

    // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t state, state_next;

    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [RD_W-1:0]   main_rd, skid_rd;
    logic              main_we, skid_we;

    logic in_fire, out_fire;
    logic load_main_in, load_main_skid, load_skid_in;

    assign main_valid = state[1];
    assign skid_valid = state[0];

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Next state and entry-load controls.
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_next   = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_next   = FULL;
                    load_skid_in = 1'b1;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // in_ready is 0 here, so only the drain side can move.
                if (out_fire) begin
                    state_next     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        // A squash drops everything held plus any same-cycle input.
        if (flush) begin
            state_next     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid_in   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Entry payload registers. With CLEAR_DATA=0 only the valid bits (the
    // state) are cleared, and stale payload simply sits behind valid=0.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            if (CLEAR_DATA) begin
                main_data <= '0;
                main_rd   <= '0;
                main_we   <= 1'b0;
                skid_data <= '0;
                skid_rd   <= '0;
                skid_we   <= 1'b0;
            end
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
                main_rd   <= in_rd;
                main_we   <= in_regwrite;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_rd   <= skid_rd;
                main_we   <= skid_we;
            end
            if (load_skid_in) begin
                skid_data <= in_data;
                skid_rd   <= in_rd;
                skid_we   <= in_regwrite;
            end
        end
    end

    assign out_data     = main_data;
    assign out_rd       = main_rd;
    assign out_regwrite = main_we & main_valid;

    // x0 is hard-wired zero, so a write to it is never a hazard.
    assign haz_rd_main = main_rd;
    assign haz_we_main = main_valid & main_we & (|main_rd);
    assign haz_rd_skid = skid_rd;
    assign haz_we_skid = skid_valid & skid_we & (|skid_rd);

    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
module tb_pipe_stage_skid_reg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int EW     = 1 + RD_W + DATA_W;  // entry = {we, rd, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [RD_W-1:0]   in_rd = '0;
  logic              in_regwrite = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [RD_W-1:0]   out_rd;
  logic              out_regwrite;
  logic [RD_W-1:0]   haz_rd_main;
  logic              haz_we_main;
  logic [RD_W-1:0]   haz_rd_skid;
  logic              haz_we_skid;
  logic [1:0]        occupancy;

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .RD_W(RD_W), .CLEAR_DATA(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_rd(in_rd), .in_regwrite(in_regwrite),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_regwrite(out_regwrite),
    .haz_rd_main(haz_rd_main), .haz_we_main(haz_we_main),
    .haz_rd_skid(haz_rd_skid), .haz_we_skid(haz_we_skid),
    .occupancy(occupancy)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The stage behaves as a FIFO of depth 2: accepts while fewer than two
  // entries are held, presents the oldest, and empties on rst or flush.
  logic [EW-1:0] exp_q[$];

  always @(posedge clk) begin
    logic mi, mo;
    mi = in_valid && (exp_q.size() < 2);
    mo = out_ready && (exp_q.size() > 0);
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (mo) void'(exp_q.pop_front());
      if (mi) exp_q.push_back({in_regwrite, in_rd, in_data});
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic [EW-1:0] m, s;
      int n;
      n = exp_q.size();
      m = (n > 0) ? exp_q[0] : '0;
      s = (n > 1) ? exp_q[1] : '0;
      check("occupancy", 64'(occupancy), 64'(n));
      check("out_valid", 64'(out_valid), 64'(n > 0));
      check("in_ready", 64'(in_ready), 64'(n < 2));
      check("no_state_01", 64'(!out_valid && occupancy != 2'd0), 64'(0));
      check("out_regwrite", 64'(out_regwrite), 64'((n > 0) && m[EW-1]));
      check("haz_we_main", 64'(haz_we_main), 64'((n > 0) && m[EW-1] && (m[DATA_W+:RD_W] != 0)));
      check("haz_we_skid", 64'(haz_we_skid), 64'((n > 1) && s[EW-1] && (s[DATA_W+:RD_W] != 0)));
      if (n > 0) begin
        check("out_data", 64'(out_data), 64'(m[DATA_W-1:0]));
        check("out_rd", 64'(out_rd), 64'(m[DATA_W+:RD_W]));
        check("haz_rd_main", 64'(haz_rd_main), 64'(m[DATA_W+:RD_W]));
      end
      if (n > 1) begin
        check("haz_rd_skid", 64'(haz_rd_skid), 64'(s[DATA_W+:RD_W]));
      end
    end
  end

  // ---------------- driver ----------------
  // Inputs change on the falling edge; returns 1 time unit after the next
  // rising edge so outputs can be sampled.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic [RD_W-1:0] rd,
                      input logic we, input logic ordy, input logic fl, input logic r);
    @(negedge clk);
    in_valid    = v;
    in_data     = d;
    in_rd       = rd;
    in_regwrite = we;
    out_ready   = ordy;
    flush       = fl;
    rst         = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    check({tag, "_occupancy"}, 64'(occupancy), 64'(0));
    check({tag, "_out_data"}, 64'(out_data), 64'(0));
    check({tag, "_out_rd"}, 64'(out_rd), 64'(0));
    check({tag, "_out_regwrite"}, 64'(out_regwrite), 64'(0));
    check({tag, "_haz_we_main"}, 64'(haz_we_main), 64'(0));
    check({tag, "_haz_we_skid"}, 64'(haz_we_skid), 64'(0));
  endtask

  initial begin
    // Reset held two cycles with a valid input present.
    step(1'b1, 32'hDEADBEEF, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hDEADBEEF, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    check_reset_state("reset");
    chk_en = 1'b1;

    // Streaming at one transfer per cycle.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, DATA_W'(i), 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("stream_out_data", 64'(out_data), 64'(i));
      check("stream_in_ready", 64'(in_ready), 64'(1));
      check("stream_occupancy", 64'(occupancy), 64'(1));
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("stream_drained", 64'(occupancy), 64'(0));

    // Back-pressure: fill both entries, then drain.
    step(1'b1, 32'h11, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h22, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bp_occupancy", 64'(occupancy), 64'(2));
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_out_data", 64'(out_data), 64'(32'h11));
    check("bp_haz_rd_main", 64'(haz_rd_main), 64'(3));
    check("bp_haz_we_main", 64'(haz_we_main), 64'(1));
    check("bp_haz_we_skid", 64'(haz_we_skid), 64'(0));
    step(1'b1, 32'h99, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);  // ignored: in_ready=0
    check("bp_hold_data", 64'(out_data), 64'(32'h11));
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("bp_drain1_data", 64'(out_data), 64'(32'h22));
    check("bp_drain1_in_ready", 64'(in_ready), 64'(1));
    check("bp_drain1_regwrite", 64'(out_regwrite), 64'(1));
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("bp_drain2_occupancy", 64'(occupancy), 64'(0));

    // Flush while full; the entry presented during flush must vanish.
    step(1'b1, 32'h33, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h44, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fl_full_occupancy", 64'(occupancy), 64'(2));
    step(1'b1, 32'h77, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    check_reset_state("flush_full");
    // Flush in ONE with an input that would otherwise be accepted.
    step(1'b1, 32'h55, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h66, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0);
    check_reset_state("flush_one");
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("flush_stays_empty", 64'(out_valid), 64'(0));

    // Simultaneous flush and reset with valid input.
    step(1'b1, 32'hABCD, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDEADBEEF, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    check_reset_state("flush_rst");
    step(1'b1, 32'h5A, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("post_rst_out_valid", 64'(out_valid), 64'(1));
    check("post_rst_out_data", 64'(out_data), 64'(32'h5A));

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 10000; c++) begin
      logic v, o, f, r, we;
      logic [RD_W-1:0] rd;
      v  = ($urandom_range(0, 9) < 7);
      o  = ($urandom_range(0, 9) < 6);
      f  = ($urandom_range(0, 63) == 0);
      r  = ($urandom_range(0, 499) == 0);
      we = $urandom_range(0, 1) == 1;
      rd = ($urandom_range(0, 3) == 0) ? RD_W'(0) : RD_W'($urandom_range(0, 31));
      step(v, $urandom, rd, we, o, f, r);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Generalised inter-stage pipeline register for the Pipelined core (ID/EX, EX/MEM, MEM/WB boundaries).
- Carries a parametrised payload plus the destination-register fields, rd and regwrite, under a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready a registered signal, so back-pressure does not form a combinational path across stages.
- Adds a synchronous flush for branch/exception squash and hazard taps that expose every in-flight destination register to the hazard/forwarding unit.

Parameters:
- DATA_W, 32: payload width in bits (control bits, operands, PC packed by the instantiating stage).
- RD_W, 5: destination register index width.
- CLEAR_DATA, 1: 1 = payload/rd registers are zeroed on reset and flush; 0 = only valid bits are cleared.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  synchronous squash of all held and incoming entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  space available; registered, equals !skid_valid.
- in_data  input  DATA_W  upstream payload.
- in_rd  input  RD_W  upstream destination register.
- in_regwrite  input  1  upstream register-write enable.
- out_valid  output  1  main entry valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  main entry payload.
- out_rd  output  RD_W  main entry rd.
- out_regwrite  output  1  main regwrite AND main_valid.
- haz_rd_main  output  RD_W  rd of main entry.
- haz_we_main  output  1  main_valid AND main regwrite AND (main rd != 0).
- haz_rd_skid  output  RD_W  rd of skid entry.
- haz_we_skid  output  1  skid_valid AND skid regwrite AND (skid rd != 0).
- occupancy  output  2  number of held entries, 0..2.

Behaviour:
- Storage: main entry (drives out_*) and skid entry. Each entry holds data, rd, regwrite and a valid bit.
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. in_valid is honoured only when in_ready=1. out_* stay stable while out_valid=1 and out_ready=0.
- States are encoded by {main_valid, skid_valid}: EMPTY = 00, ONE = 10, FULL = 11. State 01 is illegal and must never be reached.
- EMPTY: in_fire -> ONE, main <= in. Otherwise stay.
- ONE, in_fire & out_fire -> ONE, main <= in (1 transfer/cycle throughput).
- ONE, in_fire & !out_fire -> FULL, skid <= in.
- ONE, !in_fire & out_fire -> EMPTY.
- ONE, neither -> hold.
- FULL: in_ready=0, so no in_fire. out_fire -> ONE, main <= skid. Otherwise hold.
- Latency: in_fire at edge N -> out_valid with that entry from cycle N+1. Ordering is strictly FIFO.
- flush=1 (and rst=0): next cycle main_valid = skid_valid = 0, in_ready = 1. A same-cycle in_fire is discarded. A same-cycle out_fire is still counted by downstream; the block takes no extra action. If CLEAR_DATA=1, data/rd/regwrite are zeroed.
- rst=1: overrides flush and all transfers. Next cycle: out_valid=0, in_ready=1, occupancy=0, out_regwrite=0, all haz_we_*=0. If CLEAR_DATA=1, out_data=0, out_rd=0, haz_rd_*=0. Reset mid-transfer drops both entries.
- After reset the block is EMPTY, in_ready=1.
- occupancy = main_valid + skid_valid.
- A regwrite with rd=0 is never reported on haz_we_* (x0 is never a hazard). out_regwrite does pass it through; the register file ignores the write.
- No arithmetic on the payload; widths are passed through unchanged.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=0xDEADBEEF -> out_valid=0, in_ready=1, occupancy=0, out_data=0, haz_we_*=0.
- Streaming: out_ready=1, in_valid=1 with in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later each, in_ready held at 1, occupancy held at 1.
- Back-pressure: out_ready=0, push A=0x11 (rd=3, we=1) then B=0x22 (rd=0, we=1) -> occupancy=2, in_ready=0, haz_rd_main=3, haz_we_main=1, haz_we_skid=0. Then out_ready=1 -> out_data 0x11 then 0x22, in_ready returns to 1.
- Flush in FULL: two entries held, flush=1 for one cycle -> next cycle out_valid=0, occupancy=0, in_ready=1. An entry presented during the flush cycle never appears at the output.
- Simultaneous flush and rst with in_valid=1 -> identical to reset result. Then release both and push 0x5A -> out_data=0x5A next cycle.
- Random in_valid/out_ready for 10k cycles against a scoreboard queue -> no loss, duplication or reorder. State 01 is never observed. in_ready always equals !skid_valid.
